// File: rtl/cam_capture_ctrl_pkg.sv
// Shared definitions for the CMOS capture frame sequencer: state encodings,
// default 640x480 RGB565 geometry and the registered frame strobe bundle.
package cam_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        S_WAIT_CFG = 2'd0,
        S_SKIP     = 2'd1,
        S_ARM      = 2'd2,
        S_CAPTURE  = 2'd3
    } cap_state_e;

    localparam int unsigned DEF_SKIP_FRAMES = 20;
    localparam int unsigned DEF_H_WORDS     = 640;
    localparam int unsigned DEF_V_LINES     = 480;
    localparam int unsigned DEF_CNT_W       = 11;

    typedef struct packed {
        logic start;
        logic done;
        logic abort;
    } frame_evt_t;

endpackage

// File: rtl/cam_capture_ctrl_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset for single-bit
// level signals crossing into the capture clock domain.
module cam_capture_ctrl_sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-level sequencer for the CMOS capture path (cmos_pclk domain).
// Geometry checking is compiled in only when CAM_CAP_GEOM_CHECK_EN is defined.
module cam_capture_ctrl
    import cam_capture_ctrl_pkg::*;
#(
    parameter int unsigned SKIP_FRAMES = DEF_SKIP_FRAMES,
    parameter int unsigned H_WORDS     = DEF_H_WORDS,
    parameter int unsigned V_LINES     = DEF_V_LINES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             cmos_pclk,
    input  logic             rst_133,
    input  logic             cfg_done,
    input  logic             cap_run,
    input  logic             cmos_vsyn,
    input  logic             cmos_href,
    input  logic             data_16b_en,
    output logic             cap_en,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             bank_tgl,
    output logic             frame_ok,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned      SKIP_W  = $clog2(SKIP_FRAMES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef CAM_CAP_GEOM_CHECK_EN
    localparam bit GEOM_CHECK = 1'b1;
`else
    localparam bit GEOM_CHECK = 1'b0;
`endif

    logic cfg_s;
    logic run_s;

    cam_capture_ctrl_sync_2ff u_sync_cfg (
        .clk_i   (cmos_pclk),
        .rst_n_i (rst_133),
        .d_i     (cfg_done),
        .q_o     (cfg_s)
    );

    cam_capture_ctrl_sync_2ff u_sync_run (
        .clk_i   (cmos_pclk),
        .rst_n_i (rst_133),
        .d_i     (cap_run),
        .q_o     (run_s)
    );

    logic vs_q;
    logic hs_q;
    logic vs_rise;
    logic vs_fall;
    logic hs_fall;

    cap_state_e        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d, skip_inc;
    logic [CNT_W-1:0]  line_q, line_d, line_inc, line_end;
    logic [CNT_W-1:0]  word_q, word_d, word_inc, word_closing;
    logic              cap_en_q, cap_en_d;
    logic              bank_q, bank_d;
    logic              ok_q, ok_d;
    logic              bad_q, bad_d, bad_end;
    logic              line_bad;
    logic              frame_good;
    frame_evt_t        evt_q, evt_d;

    assign vs_rise = ~vs_q & cmos_vsyn;
    assign vs_fall = vs_q & ~cmos_vsyn;
    assign hs_fall = hs_q & ~cmos_href;

    // Counters stick at all-ones instead of wrapping so an oversized frame can never alias a good one.
    assign skip_inc     = skip_q + 1'b1;
    assign word_inc     = (word_q == CNT_MAX) ? word_q : word_q + 1'b1;
    assign line_inc     = (line_q == CNT_MAX) ? line_q : line_q + 1'b1;
    assign word_closing = data_16b_en ? word_inc : word_q;
    assign line_end     = hs_fall ? line_inc : line_q;

    assign line_bad   = GEOM_CHECK &&
                        ((word_closing != CNT_W'(H_WORDS)) || (word_closing == CNT_MAX));
    assign bad_end    = bad_q | (hs_fall & line_bad);
    assign frame_good = !GEOM_CHECK ||
                        ((line_end == CNT_W'(V_LINES)) && (line_end != CNT_MAX) && !bad_end);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        skip_d   = skip_q;
        line_d   = line_q;
        word_d   = word_q;
        cap_en_d = cap_en_q;
        bank_d   = bank_q;
        ok_d     = ok_q;
        bad_d    = bad_q;
        evt_d    = '0;

        if (!cfg_s) begin
            state_d     = S_WAIT_CFG;
            cap_en_d    = 1'b0;
            evt_d.abort = (state_q == S_CAPTURE);
        end else begin
            unique case (state_q)
                S_WAIT_CFG: begin
                    skip_d  = '0;
                    state_d = (SKIP_FRAMES == 0) ? S_ARM : S_SKIP;
                end
                S_SKIP: begin
                    if (vs_rise) begin
                        skip_d = skip_inc;
                        if (skip_inc == SKIP_W'(SKIP_FRAMES)) state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    // Only a vsync fall starts a frame, so arming mid-frame never yields a partial one.
                    if (run_s && vs_fall) begin
                        state_d     = S_CAPTURE;
                        cap_en_d    = 1'b1;
                        evt_d.start = 1'b1;
                        line_d      = '0;
                        word_d      = '0;
                        bad_d       = 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (data_16b_en) word_d = word_inc;
                    if (hs_fall) begin
                        line_d = line_inc;
                        word_d = '0;
                        bad_d  = bad_end;
                    end
                    if (vs_rise) begin
                        state_d    = S_ARM;
                        cap_en_d   = 1'b0;
                        evt_d.done = 1'b1;
                        ok_d       = frame_good;
                        bank_d     = bank_q ^ frame_good;
                    end
                end
                default: state_d = S_WAIT_CFG;
            endcase
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst_133) begin
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            state_q  <= S_WAIT_CFG;
            skip_q   <= '0;
            line_q   <= '0;
            word_q   <= '0;
            cap_en_q <= 1'b0;
            bank_q   <= 1'b0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            evt_q    <= '0;
        end else begin
            vs_q     <= cmos_vsyn;
            hs_q     <= cmos_href;
            state_q  <= state_d;
            skip_q   <= skip_d;
            line_q   <= line_d;
            word_q   <= word_d;
            cap_en_q <= cap_en_d;
            bank_q   <= bank_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
            evt_q    <= evt_d;
        end
    end

    assign cap_en      = cap_en_q;
    assign frame_start = evt_q.start;
    assign frame_done  = evt_q.done;
    assign frame_abort = evt_q.abort;
    assign bank_tgl    = bank_q;
    assign frame_ok    = ok_q;
    assign line_cnt    = line_q;
    assign word_cnt    = word_q;

endmodule
